// File: rtl/serializer_tx_ctrl.sv
// Transmit sequencer for the serializer_PISO datapath: captures a word over valid/ready,
// then drives LOAD and bit-rate shift strobes, frames the word with TX_active and adds an idle gap.
module serializer_tx_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned GAP_BITS     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] BUFF,
  output logic                  LOAD,
  output logic                  shift,
  output logic                  TX_active,
  output logic                  done,
  output logic [15:0]           frames_sent
);

  localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W      = $clog2(DATA_WIDTH + 1);
  localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t                  state_q, state_nxt;
  logic [BAUD_W-1:0]       baud_q, baud_nxt, baud_cur, baud_step;
  logic [BIT_W-1:0]        bit_q, bit_nxt;
  logic [GAP_W-1:0]        gap_q, gap_nxt;
  logic [DATA_WIDTH-1:0]   buff_nxt;
  logic                    load_nxt, shift_nxt, done_nxt, tx_nxt, ready_nxt;
  logic [15:0]             frames_nxt;

  // State, counters and all outputs are registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      BUFF        <= '0;
      LOAD        <= 1'b0;
      shift       <= 1'b0;
      TX_active   <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
      data_ready  <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      baud_q      <= baud_nxt;
      bit_q       <= bit_nxt;
      gap_q       <= gap_nxt;
      BUFF        <= buff_nxt;
      LOAD        <= load_nxt;
      shift       <= shift_nxt;
      TX_active   <= tx_nxt;
      done        <= done_nxt;
      frames_sent <= frames_nxt;
      data_ready  <= ready_nxt;
    end
  end

  // Outputs are computed one cycle ahead so that each strobe lands in its nominal cycle
  always_comb begin
    state_nxt  = state_q;
    baud_nxt   = baud_q;
    bit_nxt    = bit_q;
    gap_nxt    = gap_q;
    buff_nxt   = BUFF;
    load_nxt   = 1'b0;
    shift_nxt  = 1'b0;
    done_nxt   = 1'b0;
    frames_nxt = frames_sent;
    baud_cur   = (state_q == S_LOAD) ? '0 : baud_q;
    baud_step  = (baud_cur == BAUD_W'(CLKS_PER_BIT - 1)) ? '0 : baud_cur + BAUD_W'(1);

    case (state_q)
      S_IDLE: begin
        if (data_valid && data_ready) begin
          state_nxt = S_LOAD;
          buff_nxt  = data_in;
          load_nxt  = 1'b1;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      S_LOAD, S_SHIFT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (state_q == S_SHIFT && done) begin
          // last bit period has ended; done already reported this cycle
          state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          gap_nxt   = '0;
        end else begin
          state_nxt = S_SHIFT;
          baud_nxt  = baud_step;
          if (baud_step == '0 && bit_q < BIT_W'(DATA_WIDTH)) begin
            shift_nxt = 1'b1;
            bit_nxt   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
              done_nxt   = 1'b1;
              frames_nxt = frames_sent + 16'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (abort || gap_q == GAP_W'(GAP_LAST)) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_q + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = (state_nxt == S_IDLE);
    tx_nxt    = (state_nxt == S_LOAD) || (state_nxt == S_SHIFT);
  end

endmodule

// File: tb/tb_serializer_tx_ctrl.sv
// Directed bench for serializer_tx_ctrl: a per-cycle vector table on a C=1/G=0 instance,
// plus hand-written word, back-to-back, abort and reset sequences on a C=4/G=2 instance.
module tb_serializer_tx_ctrl;

  logic tb_clk = 1'b0;
  logic rst;
  always #5 tb_clk = ~tb_clk;

  // instance A: W=8, C=4, G=2
  logic [7:0]  a_din, a_buff;
  logic        a_dv, a_ready, a_ab, a_load, a_shift, a_tx, a_done;
  logic [15:0] a_frames;
  // instance B: W=8, C=1, G=0
  logic [7:0]  b_din, b_buff;
  logic        b_dv, b_ready, b_ab, b_load, b_shift, b_tx, b_done;
  logic [15:0] b_frames;

  serializer_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .GAP_BITS(2)) dut_a (
    .clk(tb_clk), .rst(rst), .data_in(a_din), .data_valid(a_dv), .data_ready(a_ready),
    .abort(a_ab), .BUFF(a_buff), .LOAD(a_load), .shift(a_shift), .TX_active(a_tx),
    .done(a_done), .frames_sent(a_frames));

  serializer_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .GAP_BITS(0)) dut_b (
    .clk(tb_clk), .rst(rst), .data_in(b_din), .data_valid(b_dv), .data_ready(b_ready),
    .abort(b_ab), .BUFF(b_buff), .LOAD(b_load), .shift(b_shift), .TX_active(b_tx),
    .done(b_done), .frames_sent(b_frames));

  typedef struct {
    logic        dv;
    logic [7:0]  din;
    logic        ab;
    logic        ready, load, shift, done, tx;
    logic [15:0] frames;
    logic [7:0]  buff;
  } vec_t;

  vec_t tbl[21];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic dv, input logic [7:0] din, input logic ab,
                              input logic ready, input logic load, input logic shift,
                              input logic done, input logic tx, input logic [15:0] frames,
                              input logic [7:0] buff);
    vec_t v;
    v.dv = dv; v.din = din; v.ab = ab; v.ready = ready; v.load = load; v.shift = shift;
    v.done = done; v.tx = tx; v.frames = frames; v.buff = buff;
    return v;
  endfunction

  task automatic chk_a(input string tag, input logic ready, input logic load, input logic sh,
                       input logic dn, input logic tx, input logic [15:0] frames,
                       input logic [7:0] buff);
    chk({tag, ".ready"},  16'(a_ready), 16'(ready));
    chk({tag, ".LOAD"},   16'(a_load),  16'(load));
    chk({tag, ".shift"},  16'(a_shift), 16'(sh));
    chk({tag, ".done"},   16'(a_done),  16'(dn));
    chk({tag, ".tx"},     16'(a_tx),    16'(tx));
    chk({tag, ".frames"}, a_frames,     frames);
    chk({tag, ".BUFF"},   16'(a_buff),  16'(buff));
  endtask

  // One word on instance A, starting in cycle 0 (data_ready already high) and ending in cycle 42.
  // abort_at=0 means no abort; hold keeps data_valid high with next_d queued behind the word.
  task automatic run_word_a(input logic [7:0] d, input logic [7:0] next_d, input bit hold,
                            input int abort_at, input logic [15:0] base);
    logic        e_load, e_sh, e_dn, e_tx, e_rdy, aborted;
    logic [15:0] e_fr;
    chk($sformatf("a_c0_ready_%02h", d), 16'(a_ready), 16'd1);
    a_din = d;
    a_dv  = 1'b1;
    for (int t = 1; t <= 42; t++) begin
      step();
      aborted = (abort_at > 0) && (t > abort_at);
      e_load  = !aborted && (t == 1);
      e_sh    = !aborted && (t > 1) && ((t - 1) % 4 == 0) && (t <= 33);
      e_dn    = !aborted && (t == 33);
      e_tx    = !aborted && (t >= 1) && (t <= 33);
      e_rdy   = aborted || (t >= 42);
      e_fr    = base + (((t >= 33) && (abort_at == 0 || abort_at >= 33)) ? 16'd1 : 16'd0);
      chk_a($sformatf("a_%02h@%0d", d, t), e_rdy, e_load, e_sh, e_dn, e_tx, e_fr, d);
      if (t == 1) begin
        if (hold) a_din = next_d;
        else begin
          a_dv  = 1'b0;
          a_din = ~d;
        end
      end
      a_ab = (t == abort_at);
    end
    a_ab = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_dv = 1'b0; a_din = 8'h00; a_ab = 1'b0;
    b_dv = 1'b0; b_din = 8'h00; b_ab = 1'b0;
    step();
    step();
    chk_a("a_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00);
    chk("b_rst.ready", 16'(b_ready), 16'd1);
    chk("b_rst.frames", b_frames, 16'd0);
    rst = 1'b0;

    // table for instance B (C=1, G=0): two words, the second handshake with abort high in IDLE
    tbl[0]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00);
    tbl[1]  = mk(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 8'hFF);
    for (int i = 2; i <= 8; i++)
      tbl[i] = mk(1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 8'hFF);
    tbl[9]  = mk(1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 8'hFF);
    tbl[10] = mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 8'hFF);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 8'h5A);
    for (int i = 12; i <= 18; i++)
      tbl[i] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 8'h5A);
    tbl[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 8'h5A);
    tbl[20] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h5A);

    for (int i = 0; i < 21; i++) begin
      step();
      chk($sformatf("b@%0d.ready", i),  16'(b_ready), 16'(tbl[i].ready));
      chk($sformatf("b@%0d.LOAD", i),   16'(b_load),  16'(tbl[i].load));
      chk($sformatf("b@%0d.shift", i),  16'(b_shift), 16'(tbl[i].shift));
      chk($sformatf("b@%0d.done", i),   16'(b_done),  16'(tbl[i].done));
      chk($sformatf("b@%0d.tx", i),     16'(b_tx),    16'(tbl[i].tx));
      chk($sformatf("b@%0d.frames", i), b_frames,     tbl[i].frames);
      chk($sformatf("b@%0d.BUFF", i),   16'(b_buff),  16'(tbl[i].buff));
      b_dv  = tbl[i].dv;
      b_din = tbl[i].din;
      b_ab  = tbl[i].ab;
    end

    // instance A: single word, back-to-back pair, aborts mid-word and on the last shift
    run_word_a(8'hA5, 8'h00, 1'b0, 0, 16'd0);
    run_word_a(8'h3C, 8'hC3, 1'b1, 0, 16'd1);
    run_word_a(8'hC3, 8'h00, 1'b0, 0, 16'd2);
    run_word_a(8'h81, 8'h00, 1'b0, 15, 16'd3);
    run_word_a(8'h7E, 8'h00, 1'b0, 33, 16'd3);

    // asynchronous reset during SHIFT
    a_din = 8'h99;
    a_dv  = 1'b1;
    step();
    a_dv = 1'b0;
    for (int t = 2; t <= 10; t++) step();
    chk("a_pre_rst.tx", 16'(a_tx), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("a_in_rst.LOAD",   16'(a_load),  16'd0);
    chk("a_in_rst.shift",  16'(a_shift), 16'd0);
    chk("a_in_rst.tx",     16'(a_tx),    16'd0);
    chk("a_in_rst.done",   16'(a_done),  16'd0);
    chk("a_in_rst.frames", a_frames,     16'd0);
    chk("a_in_rst.BUFF",   16'(a_buff),  16'd0);
    #29 rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      step();
      chk_a($sformatf("a_post_rst@%0d", t), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00);
    end
    run_word_a(8'h5A, 8'h00, 1'b0, 0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
